// File: rtl/dram_sched.sv
// rtl/dram_sched.sv - DRAM cycle scheduler arbitrating FSB RAM accesses against CAS-before-RAS refresh
//
// Ports:
//   FCLK       in   FSB clock, rising-edge state updates
//   RES        in   asynchronous active-high reset
//   BACT       in   FSB bus cycle active
//   RAMCS      in   current bus cycle addresses DRAM (qualified by BACT)
//   RefReq     in   refresh due (level, held until RefAck)
//   RefUrgent  in   refresh overdue (level)
//   RefAck     out  one-cycle pulse when a refresh is accepted
//   RASEN      out  DRAM RAS enable (active high)
//   CASEN      out  DRAM CAS enable (active high)
//   RASel      out  0 = row address, 1 = column address
//   RAM_Ready  out  FSB RAM access may terminate
//   Busy       out  scheduler is not idle
module dram_sched #(
    parameter int unsigned TRCD = 1,
    parameter int unsigned TCAS = 2,
    parameter int unsigned TRP  = 2,
    parameter int unsigned TREF = 3
) (
    input  logic FCLK,
    input  logic RES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic RefReq,
    input  logic RefUrgent,
    output logic RefAck,
    output logic RASEN,
    output logic CASEN,
    output logic RASel,
    output logic RAM_Ready,
    output logic Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAS,
        S_CAS,
        S_HOLD,
        S_REFC,
        S_REFR,
        S_PRE
    } state_t;

    localparam logic [2:0] L_TRCD = 3'(TRCD - 1);
    localparam logic [2:0] L_TCAS = 3'(TCAS - 1);
    localparam logic [2:0] L_TRP  = 3'(TRP - 1);
    localparam logic [2:0] L_TREF = 3'(TREF - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_arb;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_load;
    logic       w_access;
    logic       w_cnt_zero;

    assign w_access   = BACT & RAMCS;
    assign w_cnt_zero = (r_cnt == 3'd0);

    // Idle arbitration: an overdue refresh beats an access, an access beats a
    // plain refresh request.
    always_comb begin
        w_arb = S_IDLE;
        if (RefUrgent) begin
            w_arb = S_REFC;
        end else if (w_access) begin
            w_arb = S_RAS;
        end else if (RefReq) begin
            w_arb = S_REFC;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = w_arb;
            // A bus cycle dropped before HOLD (e.g. bus error) goes straight
            // to precharge; the FSB never sees RAM_Ready for it.
            S_RAS: begin
                if (!BACT) begin
                    w_next = S_PRE;
                end else if (w_cnt_zero) begin
                    w_next = S_CAS;
                end
            end
            S_CAS: begin
                if (!BACT) begin
                    w_next = S_PRE;
                end else if (w_cnt_zero) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!BACT) begin
                    w_next = S_PRE;
                end
            end
            S_REFC: w_next = S_REFR;
            S_REFR: begin
                if (w_cnt_zero) begin
                    w_next = S_PRE;
                end
            end
            // The last precharge cycle arbitrates in place of IDLE, so an
            // access held off by a refresh waits exactly 1+TREF+TRP cycles.
            S_PRE: begin
                if (w_cnt_zero) begin
                    w_next = w_arb;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = 3'd0;
        case (w_next)
            S_RAS:   w_cnt_load = L_TRCD;
            S_CAS:   w_cnt_load = L_TCAS;
            S_REFR:  w_cnt_load = L_TREF;
            S_PRE:   w_cnt_load = L_TRP;
            default: w_cnt_load = 3'd0;
        endcase
    end

    always_ff @(posedge FCLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Outputs decode the state register directly so an asynchronous reset
    // drops every strobe without waiting for a clock.
    assign RefAck    = (r_state == S_REFC);
    assign RASEN     = (r_state == S_RAS) || (r_state == S_CAS) ||
                       (r_state == S_HOLD) || (r_state == S_REFR);
    assign CASEN     = (r_state == S_CAS) || (r_state == S_HOLD) ||
                       (r_state == S_REFC) || (r_state == S_REFR);
    assign RASel     = (r_state == S_CAS) || (r_state == S_HOLD);
    assign RAM_Ready = (r_state == S_HOLD);
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dram_sched.sv
// tb/tb_dram_sched.sv - self-checking bench for dram_sched
module tb_dram_sched;

    localparam int TRCD = 1;
    localparam int TCAS = 2;
    localparam int TRP  = 2;
    localparam int TREF = 3;

    // expected output vectors: {RefAck, RASEN, CASEN, RASel, RAM_Ready, Busy}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_RAS  = 6'b010001;
    localparam logic [5:0] O_CAS  = 6'b011101;
    localparam logic [5:0] O_HOLD = 6'b011111;
    localparam logic [5:0] O_PRE  = 6'b000001;
    localparam logic [5:0] O_REFC = 6'b101001;
    localparam logic [5:0] O_REFR = 6'b011001;

    logic FCLK = 1'b0;
    logic RES = 1'b1;
    logic BACT = 1'b0;
    logic RAMCS = 1'b0;
    logic RefReq = 1'b0;
    logic RefUrgent = 1'b0;
    logic RefAck, RASEN, CASEN, RASel, RAM_Ready, Busy;
    logic [5:0] obs;

    int total = 0;
    int bad = 0;

    assign obs = {RefAck, RASEN, CASEN, RASel, RAM_Ready, Busy};

    dram_sched #(.TRCD(TRCD), .TCAS(TCAS), .TRP(TRP), .TREF(TREF)) dut (
        .FCLK(FCLK),
        .RES(RES),
        .BACT(BACT),
        .RAMCS(RAMCS),
        .RefReq(RefReq),
        .RefUrgent(RefUrgent),
        .RefAck(RefAck),
        .RASEN(RASEN),
        .CASEN(CASEN),
        .RASel(RASel),
        .RAM_Ready(RAM_Ready),
        .Busy(Busy)
    );

    always #5 FCLK = ~FCLK;

    typedef struct {
        logic       b;
        logic       r;
        logic       q;
        logic       u;
        logic [5:0] exp;
        int         sc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic r, input logic q, input logic u,
                       input logic [5:0] e, input int sc);
        vec_t v;
        v.b = b; v.r = r; v.q = q; v.u = u; v.exp = e; v.sc = sc;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (ack,ras,cas,sel,rdy,busy) t=%0t",
                     name, obs, exp, $time);
        end
    endtask

    // Row i: inputs sampled at one edge, outputs expected in the cycle after it.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            BACT = tbl[i].b; RAMCS = tbl[i].r; RefReq = tbl[i].q; RefUrgent = tbl[i].u;
            @(negedge FCLK);
            check($sformatf("vec%0d_sc%0d", i, tbl[i].sc), tbl[i].exp);
        end
    endtask

    // Reference model: one operation at a time, outputs derived from the
    // cycle offset inside that operation's timeline.
    int m_kind = 0;   // 0 none, 1 access, 2 refresh
    int m_off = 0;    // cycles since the operation began
    int m_pre = -1;   // access: offset where precharge begins, -1 while open

    function automatic logic [5:0] m_outs();
        if (m_kind == 0) return O_IDLE;
        if (m_kind == 2) begin
            if (m_off == 0) return O_REFC;
            if (m_off < 1 + TREF) return O_REFR;
            return O_PRE;
        end
        if (m_pre >= 0 && m_off >= m_pre) return O_PRE;
        if (m_off < TRCD) return O_RAS;
        if (m_off < TRCD + TCAS) return O_CAS;
        return O_HOLD;
    endfunction

    task automatic m_step(input logic b, input logic r, input logic q, input logic u);
        logic done;
        done = 1'b0;
        if (m_kind == 0) begin
            done = 1'b1;
        end else begin
            if (m_kind == 1 && m_pre < 0 && !b) m_pre = m_off + 1;
            m_off++;
            if (m_kind == 2 && m_off == 1 + TREF + TRP) done = 1'b1;
            if (m_kind == 1 && m_pre >= 0 && m_off == m_pre + TRP) done = 1'b1;
        end
        if (done) begin
            m_off = 0;
            m_pre = -1;
            if (u) m_kind = 2;
            else if (b && r) m_kind = 1;
            else if (q) m_kind = 2;
            else m_kind = 0;
        end
    endtask

    initial begin
        logic rb, rr, rq, ru;

        // sc1: plain read access, RAMCS dropping after RAS is ignored
        add(1,1,0,0,O_RAS,1);  add(1,1,0,0,O_CAS,1);  add(1,0,0,0,O_CAS,1);
        add(1,0,0,0,O_HOLD,1); add(1,0,0,0,O_HOLD,1); add(0,0,0,0,O_PRE,1);
        add(0,0,0,0,O_PRE,1);  add(0,0,0,0,O_IDLE,1);
        // sc2: refresh, access arriving during it is held off
        add(0,0,1,0,O_REFC,2);
        for (int i = 0; i < 3; i++) add(1,1,0,0,O_REFR,2);
        add(1,1,0,0,O_PRE,2);  add(1,1,0,0,O_PRE,2);  add(1,1,0,0,O_RAS,2);
        add(1,1,0,0,O_CAS,2);  add(1,1,0,0,O_CAS,2);  add(1,1,0,0,O_HOLD,2);
        add(0,0,0,0,O_PRE,2);  add(0,0,0,0,O_PRE,2);  add(0,0,0,0,O_IDLE,2);
        // sc3: refresh alone
        add(0,0,1,0,O_REFC,3);
        for (int i = 0; i < 3; i++) add(0,0,0,0,O_REFR,3);
        add(0,0,0,0,O_PRE,3);  add(0,0,0,0,O_PRE,3);  add(0,0,0,0,O_IDLE,3);
        // sc4: urgent refresh and access at the same edge
        add(1,1,0,1,O_REFC,4);
        for (int i = 0; i < 3; i++) add(1,1,0,0,O_REFR,4);
        add(1,1,0,0,O_PRE,4);  add(1,1,0,0,O_PRE,4);  add(1,1,0,0,O_RAS,4);
        add(1,1,0,0,O_CAS,4);  add(1,1,0,0,O_CAS,4);  add(1,1,0,0,O_HOLD,4);
        add(0,0,0,0,O_PRE,4);  add(0,0,0,0,O_PRE,4);  add(0,0,0,0,O_IDLE,4);
        // sc5: plain refresh request and access at the same edge
        add(1,1,1,0,O_RAS,5);  add(1,1,1,0,O_CAS,5);  add(1,0,1,0,O_CAS,5);
        add(1,0,1,0,O_HOLD,5); add(0,0,1,0,O_PRE,5);  add(0,0,1,0,O_PRE,5);
        add(0,0,1,0,O_REFC,5);
        for (int i = 0; i < 3; i++) add(0,0,0,0,O_REFR,5);
        add(0,0,0,0,O_PRE,5);  add(0,0,0,0,O_PRE,5);  add(0,0,0,0,O_IDLE,5);
        // sc6: access abandoned in RAS, then in CAS
        add(1,1,0,0,O_RAS,6);  add(0,1,0,0,O_PRE,6);  add(0,0,0,0,O_PRE,6);
        add(0,0,0,0,O_IDLE,6);
        add(1,1,0,0,O_RAS,6);  add(1,1,0,0,O_CAS,6);  add(0,0,0,0,O_PRE,6);
        add(0,0,0,0,O_PRE,6);  add(0,0,0,0,O_IDLE,6);
        // sc7: RAMCS without BACT
        add(0,1,0,0,O_IDLE,7); add(0,1,0,0,O_IDLE,7);

        // reset state, including with requests present while reset is held
        @(negedge FCLK);
        check("reset_idle", O_IDLE);
        BACT = 1; RAMCS = 1; RefUrgent = 1;
        @(negedge FCLK);
        check("reset_held", O_IDLE);
        BACT = 0; RAMCS = 0; RefUrgent = 0;
        RES = 0;

        run_rows(0, tbl.size() - 1);

        // asynchronous reset while in CAS
        BACT = 1; RAMCS = 1;
        @(negedge FCLK);
        check("pre_reset_ras", O_RAS);
        @(negedge FCLK);
        check("pre_reset_cas", O_CAS);
        #2 RES = 1;
        #1 check("async_reset", O_IDLE);
        BACT = 0; RAMCS = 0;
        @(negedge FCLK);
        RES = 0;
        run_rows(0, 7);

        // randomized traffic against the reference model
        rb = 0; rq = 0;
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] e;
            e = m_outs();
            check("rand", e);
            if (e[5]) rq = 0;
            else if (!rq && $urandom_range(0, 9) == 0) rq = 1;
            ru = rq && ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 4) == 0) rb = ~rb;
            rr = ($urandom_range(0, 3) != 0);
            BACT = rb; RAMCS = rr; RefReq = rq; RefUrgent = ru;
            m_step(rb, rr, rq, ru);
            @(negedge FCLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
